lcd1602_responder: RTL and testbench

HD44780-compatible LCD responder for the 1602 display bus. It is the device-side counterpart of the team's LCD1602 host controllers. The block samples LCD_EN/RS/RW/DATA on the 50 MHz system clock and decodes the instruction set. It maintains DDRAM, CGRAM, the address counter, the busy flag and mode state, and answers status and data reads. A registered display port lets downstream logic (simulation checker, text overlay) read the display contents.

---
 rtl/lcd1602_responder_if.sv | 19 +
 rtl/lcd1602_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_lcd1602_responder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd1602_responder_if.sv
// rtl/lcd1602_responder_if.sv - LCD1602 host bus between controller (master) and responder (slave)
interface lcd1602_responder_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (
    output lcd_en, lcd_rs, lcd_rw, lcd_data_in,
    input  lcd_data_out, lcd_data_oe
  );

  modport slave (
    input  lcd_en, lcd_rs, lcd_rw, lcd_data_in,
    output lcd_data_out, lcd_data_oe
  );
endinterface

// File: rtl/lcd1602_responder.sv
// rtl/lcd1602_responder.sv - HD44780-compatible device-side model of the 1602 LCD bus
// Samples the asynchronous host bus, decodes instructions, holds DDRAM/CGRAM and exposes a display port.
module lcd1602_responder #(
  parameter int unsigned BUSY_SHORT = 2000,
  parameter int unsigned BUSY_LONG  = 76000
) (
  input  logic                     clock,
  input  logic                     reset,
  lcd1602_responder_if.slave       bus,
  output logic                     busy,
  output logic                     ovr_err,
  output logic                     disp_on,
  output logic                     cursor_on,
  output logic                     blink_on,
  output logic                     entry_id,
  output logic                     entry_s,
  output logic                     func_dl,
  output logic                     func_n,
  output logic                     func_f,
  output logic [5:0]               shift_offset,
  input  logic [6:0]               disp_addr,
  output logic [7:0]               disp_char
);

  localparam int CW = $clog2(BUSY_LONG + 1);

  typedef enum logic [1:0] {ST_POR, ST_SWEEP, ST_IDLE} state_t;

  state_t        state;
  logic [6:0]    sweep_idx;
  logic [CW-1:0] cnt;
  logic [6:0]    ac;
  logic          sel_dd;
  logic          oe_r;
  logic [7:0]    dout_r;

  logic       en_s1, en_s2, en_s3;
  logic       rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0] data_s1, data_s2;
  logic       rise_q, fall_q, rs_q, rw_q;
  logic [7:0] din_q;

  logic [7:0] ddram [0:79];
  logic [7:0] cgram [0:63];

  // {valid, linear index}: rows 0x00-0x27 and 0x40-0x67 map onto 0..79
  function automatic logic [7:0] dd_map(input logic [6:0] a);
    if (a <= 7'h27)
      dd_map = {1'b1, a};
    else if (a >= 7'h40 && a <= 7'h67)
      dd_map = {1'b1, a - 7'h18};
    else
      dd_map = 8'h00;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic dd, input logic up);
    logic [7:0] m;
    m = dd_map(a);
    if (!dd)
      ac_step = {1'b0, up ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    else if (!m[7])
      ac_step = 7'h00;
    else if (up)
      ac_step = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else
      ac_step = (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
  endfunction

  function automatic logic [5:0] sh_step(input logic [5:0] s, input logic up);
    if (up)
      sh_step = (s == 6'd39) ? 6'd0 : s + 6'd1;
    else
      sh_step = (s == 6'd0) ? 6'd39 : s - 6'd1;
  endfunction

  logic       sweeping;
  logic       wr_acc;
  logic [7:0] ac_map;
  logic [7:0] disp_map;
  logic       dd_we;
  logic [6:0] dd_idx;
  logic [7:0] dd_wdata;
  logic       cg_we;
  logic [7:0] ram_rd;

  assign busy = (cnt != '0) || (state == ST_POR);
  assign bus.lcd_data_oe  = oe_r;
  assign bus.lcd_data_out = dout_r;

  always_comb begin
    sweeping = (state == ST_SWEEP);
    wr_acc   = fall_q && !rw_q && !busy;
    ac_map   = dd_map(ac);
    disp_map = dd_map(disp_addr);
    dd_we    = sweeping || (wr_acc && rs_q && sel_dd && ac_map[7]);
    dd_idx   = sweeping ? sweep_idx : ac_map[6:0];
    dd_wdata = sweeping ? 8'h20 : din_q;
    cg_we    = wr_acc && rs_q && !sel_dd;
    if (sel_dd)
      ram_rd = ac_map[7] ? ddram[ac_map[6:0]] : 8'h20;
    else
      ram_rd = cgram[ac[5:0]];
  end

  // Memories carry no reset; the DDRAM clear sweep gives them defined contents
  always_ff @(posedge clock) begin
    if (dd_we)
      ddram[dd_idx] <= dd_wdata;
    if (cg_we)
      cgram[ac[5:0]] <= din_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_POR;
      sweep_idx    <= 7'd0;
      cnt          <= '0;
      ac           <= 7'd0;
      sel_dd       <= 1'b1;
      oe_r         <= 1'b0;
      dout_r       <= 8'h00;
      ovr_err      <= 1'b0;
      disp_on      <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      entry_id     <= 1'b1;
      entry_s      <= 1'b0;
      func_dl      <= 1'b1;
      func_n       <= 1'b0;
      func_f       <= 1'b0;
      shift_offset <= 6'd0;
      disp_char    <= 8'h20;
      en_s1 <= 1'b0; en_s2 <= 1'b0; en_s3 <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0; rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      data_s1 <= 8'h00; data_s2 <= 8'h00;
      rise_q <= 1'b0; fall_q <= 1'b0; rs_q <= 1'b0; rw_q <= 1'b0;
      din_q  <= 8'h00;
    end else begin
      en_s1   <= bus.lcd_en;       en_s2   <= en_s1;   en_s3 <= en_s2;
      rs_s1   <= bus.lcd_rs;       rs_s2   <= rs_s1;
      rw_s1   <= bus.lcd_rw;       rw_s2   <= rw_s1;
      data_s1 <= bus.lcd_data_in;  data_s2 <= data_s1;
      rise_q  <= en_s2 && !en_s3;
      fall_q  <= !en_s2 && en_s3;
      rs_q    <= rs_s2;
      rw_q    <= rw_s2;
      din_q   <= data_s2;

      // Forward a same-cycle DDRAM write so the display port sees it one clock later
      if (!disp_map[7])
        disp_char <= 8'h20;
      else if (dd_we && dd_idx == disp_map[6:0])
        disp_char <= dd_wdata;
      else
        disp_char <= ddram[disp_map[6:0]];

      if (cnt != '0)
        cnt <= cnt - CW'(1);

      case (state)
        ST_POR: begin
          state     <= ST_SWEEP;
          sweep_idx <= 7'd0;
          cnt       <= CW'(BUSY_LONG);
        end
        ST_SWEEP: begin
          sweep_idx <= sweep_idx + 7'd1;
          if (sweep_idx == 7'd79)
            state <= ST_IDLE;
        end
        default: ;
      endcase

      if (rise_q && rw_q) begin
        oe_r   <= 1'b1;
        dout_r <= rs_q ? ram_rd : {busy, ac};
      end

      if (fall_q) begin
        oe_r <= 1'b0;
        if (rw_q) begin
          if (rs_q) begin
            ac <= ac_step(ac, sel_dd, entry_id);
            if (!busy)
              cnt <= CW'(BUSY_SHORT);
          end
        end else if (busy) begin
          ovr_err <= 1'b1;
        end else if (rs_q) begin
          cnt <= CW'(BUSY_SHORT);
          ac  <= ac_step(ac, sel_dd, entry_id);
          if (entry_s && sel_dd)
            shift_offset <= sh_step(shift_offset, entry_id);
        end else begin
          cnt <= CW'(BUSY_SHORT);
          casez (din_q)
            8'b1???????: begin
              ac     <= din_q[6:0];
              sel_dd <= 1'b1;
            end
            8'b01??????: begin
              ac     <= {1'b0, din_q[5:0]};
              sel_dd <= 1'b0;
            end
            8'b001?????: begin
              func_dl <= din_q[4];
              func_n  <= din_q[3];
              func_f  <= din_q[2];
            end
            8'b0001????: begin
              if (din_q[3])
                shift_offset <= sh_step(shift_offset, din_q[2]);
              else
                ac <= ac_step(ac, sel_dd, din_q[2]);
            end
            8'b00001???: begin
              disp_on   <= din_q[2];
              cursor_on <= din_q[1];
              blink_on  <= din_q[0];
            end
            8'b000001??: begin
              entry_id <= din_q[1];
              entry_s  <= din_q[0];
            end
            8'b0000001?: begin
              cnt          <= CW'(BUSY_LONG);
              ac           <= 7'd0;
              shift_offset <= 6'd0;
              sel_dd       <= 1'b1;
            end
            8'b00000001: begin
              cnt          <= CW'(BUSY_LONG);
              ac           <= 7'd0;
              shift_offset <= 6'd0;
              sel_dd       <= 1'b1;
              entry_id     <= 1'b1;
              state        <= ST_SWEEP;
              sweep_idx    <= 7'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd1602_responder.sv
// tb/tb_lcd1602_responder.sv - directed self-checking bench for lcd1602_responder
// Shortened busy windows keep the run brief; the long window still covers the 80-cycle sweep.
module tb_lcd1602_responder;
  localparam int BS = 40;
  localparam int BL = 150;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       busy, ovr_err;
  logic       disp_on, cursor_on, blink_on, entry_id, entry_s;
  logic       func_dl, func_n, func_f;
  logic [5:0] shift_offset;
  logic [6:0] disp_addr = 7'd0;
  logic [7:0] disp_char;

  int n_checks = 0;
  int n_fail   = 0;

  lcd1602_responder_if bus ();

  lcd1602_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .busy(busy), .ovr_err(ovr_err),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_id(entry_id), .entry_s(entry_s),
    .func_dl(func_dl), .func_n(func_n), .func_f(func_f),
    .shift_offset(shift_offset),
    .disp_addr(disp_addr), .disp_char(disp_char)
  );

  always #10 clock = ~clock;

  task automatic wait_ready();
    int k = 0;
    while (busy && k < 1000) begin
      @(negedge clock);
      k++;
    end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ready: busy=%b after %0d clocks, required 0", busy, k);
    end
  endtask

  task automatic lcd_write(input logic rs, input logic [7:0] d);
    bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_data_in = d;
    repeat (4) @(negedge clock);
    bus.lcd_en = 1'b1;
    repeat (6) @(negedge clock);
    bus.lcd_en = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic write_rdy(input logic rs, input logic [7:0] d);
    wait_ready();
    lcd_write(rs, d);
  endtask

  task automatic lcd_read(input logic rs, output logic [7:0] d,
                          output logic oe_early, output logic oe_high, output logic oe_after);
    bus.lcd_rs = rs; bus.lcd_rw = 1'b1;
    repeat (4) @(negedge clock);
    bus.lcd_en = 1'b1;
    repeat (2) @(negedge clock);
    oe_early = bus.lcd_data_oe;
    repeat (4) @(negedge clock);
    oe_high = bus.lcd_data_oe;
    d = bus.lcd_data_out;
    bus.lcd_en = 1'b0;
    repeat (6) @(negedge clock);
    oe_after = bus.lcd_data_oe;
    bus.lcd_rw = 1'b0;
  endtask

  task automatic peek(input logic [6:0] a, output logic [7:0] c);
    disp_addr = a;
    repeat (2) @(negedge clock);
    c = disp_char;
  endtask

  task automatic test_reset();
    logic [7:0] c;
    logic [6:0] addrs [4];
    addrs[0] = 7'h00; addrs[1] = 7'h27; addrs[2] = 7'h40; addrs[3] = 7'h67;
    bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data_in = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.lcd_data_oe !== 1'b0 || bus.lcd_data_out !== 8'h00 || ovr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: oe=%b out=%h ovr=%b, required 0 00 0",
               bus.lcd_data_oe, bus.lcd_data_out, ovr_err);
    end
    reset = 1'b1;
    repeat (BL) @(negedge clock);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL por_busy_held: busy=%b, required 1", busy);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL por_busy_release: busy=%b, required 0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      peek(addrs[i], c);
      n_checks++;
      if (c !== 8'h20) begin
        n_fail++; $display("FAIL por_blank[%h]: got %h, required 20", addrs[i], c);
      end
    end
    n_checks++;
    if (func_dl !== 1'b1 || entry_id !== 1'b1 || func_n !== 1'b0 || disp_on !== 1'b0 || shift_offset !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_modes: dl=%b id=%b n=%b d=%b sh=%0d, required 1 1 0 0 0",
               func_dl, entry_id, func_n, disp_on, shift_offset);
    end
  endtask

  task automatic test_hello();
    string s1 = "Hello,Jackin!";
    string s2 = "Welcome";
    logic [7:0] init_seq [7];
    logic [7:0] c, st;
    logic e, h, a;
    init_seq[0] = 8'h01; init_seq[1] = 8'h02; init_seq[2] = 8'h06; init_seq[3] = 8'h0C;
    init_seq[4] = 8'h14; init_seq[5] = 8'h38; init_seq[6] = 8'h80;
    for (int i = 0; i < 7; i++) write_rdy(1'b0, init_seq[i]);
    for (int i = 0; i < s1.len(); i++) write_rdy(1'b1, s1[i]);
    write_rdy(1'b0, 8'hC0);
    for (int i = 0; i < s2.len(); i++) write_rdy(1'b1, s2[i]);
    wait_ready();
    peek(7'h00, c);
    n_checks++;
    if (c !== "H") begin n_fail++; $display("FAIL hello_00: got %h, required %h", c, 8'h48); end
    peek(7'h0C, c);
    n_checks++;
    if (c !== "!") begin n_fail++; $display("FAIL hello_0c: got %h, required %h", c, 8'h21); end
    peek(7'h40, c);
    n_checks++;
    if (c !== "W") begin n_fail++; $display("FAIL hello_40: got %h, required %h", c, 8'h57); end
    peek(7'h46, c);
    n_checks++;
    if (c !== "e") begin n_fail++; $display("FAIL hello_46: got %h, required %h", c, 8'h65); end
    n_checks++;
    if (disp_on !== 1'b1 || func_n !== 1'b1 || cursor_on !== 1'b0 || func_dl !== 1'b1) begin
      n_fail++;
      $display("FAIL hello_modes: d=%b n=%b c=%b dl=%b, required 1 1 0 1", disp_on, func_n, cursor_on, func_dl);
    end
    lcd_read(1'b0, st, e, h, a);
    n_checks++;
    if (st !== 8'h47) begin n_fail++; $display("FAIL hello_status: got %h, required 47", st); end
  endtask

  task automatic test_status_busy();
    logic [7:0] st, c;
    logic e, h, a;
    write_rdy(1'b0, 8'h01);
    lcd_read(1'b0, st, e, h, a);
    n_checks++;
    if (st !== 8'h80) begin n_fail++; $display("FAIL status_busy: got %h, required 80", st); end
    n_checks++;
    if (e !== 1'b0 || h !== 1'b1 || a !== 1'b0) begin
      n_fail++; $display("FAIL status_oe: early=%b high=%b after=%b, required 0 1 0", e, h, a);
    end
    wait_ready();
    peek(7'h00, c);
    n_checks++;
    if (c !== 8'h20) begin n_fail++; $display("FAIL clear_00: got %h, required 20", c); end
  endtask

  task automatic test_wrap();
    logic [7:0] c;
    write_rdy(1'b0, 8'hA7);
    write_rdy(1'b1, "A");
    write_rdy(1'b1, "B");
    wait_ready();
    peek(7'h27, c);
    n_checks++;
    if (c !== "A") begin n_fail++; $display("FAIL wrap_inc_27: got %h, required %h", c, 8'h41); end
    peek(7'h40, c);
    n_checks++;
    if (c !== "B") begin n_fail++; $display("FAIL wrap_inc_40: got %h, required %h", c, 8'h42); end
    write_rdy(1'b0, 8'h04);
    write_rdy(1'b0, 8'h80);
    write_rdy(1'b1, "X");
    write_rdy(1'b1, "Y");
    wait_ready();
    peek(7'h00, c);
    n_checks++;
    if (c !== "X") begin n_fail++; $display("FAIL wrap_dec_00: got %h, required %h", c, 8'h58); end
    peek(7'h67, c);
    n_checks++;
    if (c !== "Y") begin n_fail++; $display("FAIL wrap_dec_67: got %h, required %h", c, 8'h59); end
  endtask

  task automatic test_overrun();
    logic [7:0] c;
    write_rdy(1'b0, 8'h06);
    wait_ready();
    n_checks++;
    if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b, required 0", ovr_err); end
    lcd_write(1'b0, 8'h85);
    lcd_write(1'b1, "Z");
    n_checks++;
    if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b, required 1", ovr_err); end
    write_rdy(1'b1, "M");
    wait_ready();
    peek(7'h05, c);
    n_checks++;
    if (c !== "M") begin n_fail++; $display("FAIL ovr_05: got %h, required %h", c, 8'h4D); end
    peek(7'h06, c);
    n_checks++;
    if (c !== 8'h20) begin n_fail++; $display("FAIL ovr_06: got %h, required 20", c); end
    n_checks++;
    if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b, required 1", ovr_err); end
  endtask

  task automatic test_cgram();
    logic [7:0] d;
    logic e, h, a;
    write_rdy(1'b0, 8'h7F);
    write_rdy(1'b1, 8'h1F);
    write_rdy(1'b1, 8'h11);
    write_rdy(1'b0, 8'h7F);
    wait_ready();
    lcd_read(1'b1, d, e, h, a);
    n_checks++;
    if (d !== 8'h1F) begin n_fail++; $display("FAIL cg_3f: got %h, required 1f", d); end
    wait_ready();
    lcd_read(1'b1, d, e, h, a);
    n_checks++;
    if (d !== 8'h11) begin n_fail++; $display("FAIL cg_00: got %h, required 11", d); end
    wait_ready();
    lcd_read(1'b0, d, e, h, a);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL cg_ac: got %h, required 01", d); end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_status_busy();
    test_wrap();
    test_overrun();
    test_cgram();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
